// File: rtl/wb_deserializer_pkg.sv
// wb_deserializer_pkg: shared constants, register map and receiver state type
package WBDeserializer;
  localparam logic [31:0] ADR_DATA   = 32'h0;
  localparam logic [31:0] ADR_STATUS = 32'h4;
  localparam int ST_VALID = 0;
  localparam int ST_FERR  = 1;
  localparam int ST_OVR   = 2;
  localparam int ST_IDX   = 3;
  localparam int SYM_W = 9;
  localparam int PKT_W = 27;
  typedef enum logic [2:0] {IDLE, START, BITS, STOP, WAITHI} rx_state_e;
endpackage

// File: rtl/wb_deserializer_symbol_rx.sv
// symbol_rx: serial line synchronizer and framed 9-bit symbol receiver
module symbol_rx
  import WBDeserializer::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             serial_i,
  output logic [SYM_W-1:0] sym_o,
  output logic             sym_valid_o,
  output logic             sym_err_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  rx_state_e st_q;
  logic s1_q, s2_q;
  logic [CW-1:0] cnt_q;
  logic [3:0] nb_q;
  // synchronizer flops reset high so reset release never looks like a start edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q        <= 1'b1;
      s2_q        <= 1'b1;
      st_q        <= IDLE;
      cnt_q       <= '0;
      nb_q        <= '0;
      sym_o       <= '0;
      sym_valid_o <= 1'b0;
      sym_err_o   <= 1'b0;
    end else begin
      s1_q        <= serial_i;
      s2_q        <= s1_q;
      sym_valid_o <= 1'b0;
      sym_err_o   <= 1'b0;
      cnt_q       <= cnt_q + 1'b1;
      case (st_q)
        IDLE: begin
          cnt_q <= '0;
          nb_q  <= '0;
          st_q  <= s2_q ? IDLE : START;
        end
        START: if (cnt_q == HALF) begin
          cnt_q <= '0;
          st_q  <= s2_q ? IDLE : BITS;
        end
        BITS: if (cnt_q == LAST) begin
          cnt_q <= '0;
          sym_o <= {sym_o[SYM_W-2:0], s2_q};
          nb_q  <= nb_q + 4'd1;
          st_q  <= (nb_q == 4'd8) ? STOP : BITS;
        end
        STOP: if (cnt_q == LAST) begin
          cnt_q       <= '0;
          sym_valid_o <= s2_q;
          sym_err_o   <= ~s2_q;
          st_q        <= s2_q ? IDLE : WAITHI;
        end
        WAITHI: st_q <= s2_q ? IDLE : WAITHI;
        default: st_q <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/wb_deserializer.sv
// wb_deserializer: symbol-to-packet assembler with status flags behind a Wishbone slave
module wb_deserializer
  import WBDeserializer::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        SERIAL_I,
  output logic        irq_o,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [31:0] ADR_I,
  input  logic [31:0] DAT_I,
  output logic        ACK_O,
  output logic        ERR_O,
  output logic [31:0] DAT_O
);
  logic [SYM_W-1:0] sym, slot0_q, slot0_d, slot1_q, slot1_d;
  logic sym_valid, sym_err;
  logic [1:0] idx_q, idx_d;
  logic [PKT_W-1:0] pkt_q, pkt_d;
  logic valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic ack_q, ack_d, err_q, err_d;
  logic [31:0] dat_q, dat_d, status;
  logic req, hit_data, hit_stat, ok, rd_data, w1c, load;
  logic unused_dat;
  symbol_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_i      (CLK_I),
    .rst_i      (RST_I),
    .serial_i   (SERIAL_I),
    .sym_o      (sym),
    .sym_valid_o(sym_valid),
    .sym_err_o  (sym_err)
  );
  assign unused_dat = ^{DAT_I[31:3], DAT_I[0]};
  // a response blocks the next request for one cycle, giving one response per strobe
  always_comb begin
    req      = CYC_I & STB_I & ~ack_q & ~err_q;
    hit_data = ADR_I == ADR_DATA;
    hit_stat = ADR_I == ADR_STATUS;
    ok       = (hit_data & ~WE_I) | hit_stat;
    rd_data  = req & hit_data & ~WE_I;
    w1c      = req & hit_stat & WE_I;
    load     = sym_valid & (idx_q == 2'd2);
    status   = {27'b0, idx_q, ovr_q, ferr_q, valid_q};
    idx_d    = sym_err ? 2'd0 : sym_valid ? (load ? 2'd0 : idx_q + 2'd1) : idx_q;
    slot0_d  = sym_err ? '0 : (sym_valid && idx_q == 2'd0) ? sym : slot0_q;
    slot1_d  = sym_err ? '0 : (sym_valid && idx_q == 2'd1) ? sym : slot1_q;
    pkt_d    = load ? {slot0_q, slot1_q, sym} : pkt_q;
    valid_d  = load | (valid_q & ~rd_data);
    ovr_d    = (load & valid_q) | (ovr_q & ~(w1c & DAT_I[ST_OVR]));
    ferr_d   = sym_err | (ferr_q & ~(w1c & DAT_I[ST_FERR]));
    ack_d    = req & ok;
    err_d    = req & ~ok;
    dat_d    = (req & ok & ~WE_I) ? (hit_data ? {{(32-PKT_W){1'b0}}, pkt_q} : status) : 32'b0;
  end
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      idx_q   <= '0;
      slot0_q <= '0;
      slot1_q <= '0;
      pkt_q   <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      idx_q   <= idx_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      pkt_q   <= pkt_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end
  assign irq_o = valid_q;
  assign ACK_O = ack_q;
  assign ERR_O = err_q;
  assign DAT_O = dat_q;
endmodule

// File: doc/wb_deserializer.md
# wb_deserializer

Receive end of the serial symbol link driven by the Wishbone serializer. Recovers 10-bit framed symbols from a single serial line and assembles three consecutive 9-bit symbols into one 27-bit packet. The packet layout is `[k+8][k+8][k+8]`, where k=1 marks a K-code and k=0 marks data. The packet and a status register are exposed as a Wishbone slave for the CPU-side master.

## Interface
Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range ≥ 4, even.

Ports:
- CLK_I  in  1  system/Wishbone clock; sole clock of the block.
- RST_I  in  1  reset; synchronous, active-high.
- SERIAL_I  in  1  serial line, asynchronous to CLK_I; idles high.
- irq_o  out  1  level, equals the VALID flag.
- CYC_I  in  1  Wishbone cycle.
- STB_I  in  1  Wishbone strobe.
- WE_I  in  1  Wishbone write enable.
- ADR_I  in  32  Wishbone byte address.
- DAT_I  in  32  Wishbone write data.
- ACK_O  out  1  Wishbone acknowledge.
- ERR_O  out  1  Wishbone error.
- DAT_O  out  32  Wishbone read data.

## Operation
- **Input synchronizer:** SERIAL_I passes through a 2-flop synchronizer. Both flops reset to 1, so reset cannot create a false start edge.
- **Symbol frame, 10 bit times, then a stop bit:**
  - start bit = 0, then k, then d[7:0] MSB first;
  - followed by one stop bit = 1.
- **Receiver FSM:**
  - IDLE: on a synchronized falling edge → START.
  - START: wait CLKS_PER_BIT/2 cycles, then sample. If the sample is 0 → BITS; if 1 → IDLE (false start, no flag).
  - BITS: sample every CLKS_PER_BIT cycles, 9 samples, shifting into sym[8:0] (k lands in sym[8]) → STOP.
  - STOP: after CLKS_PER_BIT cycles, sample the stop bit.
    - 1: pulse sym_valid for one cycle → IDLE.
    - 0: pulse sym_err for one cycle → WAITHI.
  - WAITHI: stay until the line reads 1 → IDLE.
- **Packet assembler:**
  - idx (0..2) counts received symbols. sym_valid writes the symbol into slot idx and increments idx.
  - Slot 0 maps to packet[26:18], slot 1 to [17:9], slot 2 to [8:0].
  - When idx==2: load PKT, set VALID, return idx to 0. If VALID was already 1, also set OVR; PKT is overwritten (newest packet wins).
  - sym_err clears idx to 0, sets FERR and discards partial slots.
- **Register map** (full 32-bit address compare; constants in package):
  - ADR_DATA = 0x0, read-only: DAT_O = {5'b0, PKT}. An acked read clears VALID.
  - ADR_STATUS = 0x4.
    - Read: DAT_O = {27'b0, idx[1:0], OVR, FERR, VALID}, with VALID in bit 0.
    - Write: W1C. DAT_I[1] clears FERR; DAT_I[2] clears OVR; VALID is not writable.
  - A write to ADR_DATA, or any access to an unmapped address, returns ERR_O instead of ACK_O and has no side effect.
- **Simultaneous events:**
  - A set event beats a clear in the same cycle: a new packet during a DATA read leaves VALID=1, and the reader gets the old PKT.
  - An error during a FERR W1C leaves FERR=1.
- **Reset mid-frame:**
  - FSM → IDLE, idx=0, slots cleared.
  - PKT=0, VALID/FERR/OVR=0, and the partial symbol is discarded.

## Timing
- **Reset values:** ACK_O=0, ERR_O=0, DAT_O=0, irq_o=0.
- **Sample point:** data bit n is sampled CLKS_PER_BIT/2 + (n+1)·CLKS_PER_BIT cycles after the synchronized falling edge. Add 2 cycles of synchronizer latency from the raw SERIAL_I edge.
- **Packet latency:** sym_valid asserts in the stop-sample cycle. PKT and VALID (and irq_o) update on the next clock edge.
- **Wishbone handshake:**
  - ACK_O/ERR_O are registered: asserted one cycle after CYC_I&STB_I is sampled high.
  - The response lasts exactly one cycle, then drops for one cycle even if STB_I stays high (one response per strobe).
  - ACK_O and ERR_O are never high together.
  - DAT_O is valid only with ACK_O and is 0 otherwise.
  - Side effects (VALID clear, W1C) take effect on the ACK cycle edge.
- **Strobe withdrawn:** if STB_I drops before the response, no response is generated.

## Structure
- **Package `WBDeserializer`:**
  - ADR_DATA and ADR_STATUS;
  - STATUS bit indices;
  - SYM_W = 9, PKT_W = 27;
  - the receiver state enum (IDLE, START, BITS, STOP, WAITHI).
- **Sub-module `symbol_rx`:** synchronizer plus receiver FSM. Outputs sym[8:0], sym_valid and sym_err; parameter CLKS_PER_BIT.
- **Top level:** assembler, flags and the Wishbone slave.

## Test plan
- **Good packet:** CLKS_PER_BIT=16; send symbols 0x1BC, 0x012, 0x034 → irq_o=1; reading 0x0 returns 0x06F02434 with ACK_O; status reads 0x0 afterwards.
- **Frame error:** send 0x1BC, then a symbol with stop bit 0 → status = 0x02 (FERR=1, idx=0). Then send 3 good symbols → a valid packet is assembled. W1C 0x2 to 0x4 → FERR=0.
- **Overrun:** send two packets without reading → status = 0x05. A DATA read returns the second packet.
- **False start:** a low glitch of 4 cycles → no sym_valid, idx unchanged, no flags.
- **Bus errors:** a write to 0x0, or a read of 0x8 → ERR_O pulse, ACK_O=0, state unchanged.
- **Collision and reset:**
  - A DATA read acked in the same cycle as a new packet load → old PKT returned, VALID stays 1.
  - RST_I asserted mid-symbol → all outputs and flags 0; the next full packet is received correctly.
